// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_feeder
// Description : Byte FIFO feeding a pulse-triggered UART transmitter with a
//               ready/busy handshake. Define UART_TX_FEEDER_OVF_EN to enable
//               the sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_feeder #(
    parameter int DEPTH     = 16,
    parameter int PULSE_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [7:0]               tx_data,
    output logic                     tx_data_valid,
    input  logic                     tx_ready
);

    localparam int c_AW = $clog2(DEPTH);

    localparam logic [c_AW-1:0] c_PTR_ONE  = 1;
    localparam logic [c_AW:0]   c_CNT_ONE  = 1;
    localparam logic [c_AW:0]   c_CNT_FULL = (c_AW + 1)'(DEPTH);
    localparam logic [3:0]      c_PULSE    = 4'(PULSE_LEN);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_PULSE_ST  = 2'd1;
    localparam logic [1:0] c_WAIT_BUSY = 2'd2;
    localparam logic [1:0] c_WAIT_DONE = 2'd3;

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [1:0]      r_state;
    logic [3:0]      r_pulse_cnt;
    logic [7:0]      r_tx_data;
    logic            r_tx_valid;

    logic w_full;
    logic w_empty;
    logic w_wr_accept;
    logic w_pop;

    assign w_full  = (r_count == c_CNT_FULL);
    assign w_empty = (r_count == '0);

    // A write against a full FIFO is dropped even if a pop frees a slot on the same edge.
    assign w_wr_accept = wr_en && !w_full;
    assign w_pop       = (r_state == c_IDLE) && !w_empty && tx_ready;

    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_wr_accept, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_pulse_cnt <= '0;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_pop) begin
                        r_tx_data   <= r_mem[r_rd_ptr];
                        r_tx_valid  <= 1'b1;
                        r_pulse_cnt <= 4'd1;
                        r_state     <= c_PULSE_ST;
                    end
                end
                c_PULSE_ST: begin
                    if (r_pulse_cnt == c_PULSE) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= c_WAIT_BUSY;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + 4'd1;
                    end
                end
                // Wait for the transmitter to acknowledge by going busy, then idle again.
                c_WAIT_BUSY: begin
                    if (!tx_ready) begin
                        r_state <= c_WAIT_DONE;
                    end
                end
                c_WAIT_DONE: begin
                    if (tx_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FEEDER_OVF_EN
    logic r_overflow;
    logic w_drop;

    assign w_drop = wr_en && w_full;

    // A drop coinciding with a clear wins, so no dropped write goes unreported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop || (r_overflow && !ovf_clr);
        end
    end

    assign overflow = r_overflow;
`else
    logic w_unused_ovf_clr;
    assign w_unused_ovf_clr = ovf_clr;
    assign overflow         = 1'b0;
`endif

    assign full          = w_full;
    assign empty         = w_empty;
    assign count         = r_count;
    assign tx_data       = r_tx_data;
    assign tx_data_valid = r_tx_valid;

endmodule
`default_nettype wire
